// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: word/line widths plus the L1/L2 arbiter state and owner enums.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_L1_line;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D,
      RELEASE
   } lc3b_arb_state;

   typedef enum logic {
      ICACHE,
      DCACHE
   } lc3b_arb_owner;

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer: f = sel ? b : a.
module mux2 #(
   parameter int unsigned Width = 16
) (
   input  logic             sel,
   input  logic [Width-1:0] a,
   input  logic [Width-1:0] b,
   output logic [Width-1:0] f
);

   assign f = sel ? b : a;

endmodule

// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter between the L1 icache and dcache onto the single shared L2 port,
// with a sticky flag for L2 transactions that overrun a cycle budget.
module l1_l2_arbiter
   import lc3b_types::*;
#(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic         clk,
   input  logic         rst_n,

   input  logic [15:0]  icache_L2_address,
   input  logic         icache_L2_read,
   output logic [127:0] icache_L2_rdata,
   output logic         icache_L2_resp,

   input  logic [15:0]  dcache_L2_address,
   input  logic         dcache_L2_read,
   input  logic         dcache_L2_write,
   input  logic [127:0] dcache_L2_wdata,
   output logic [127:0] dcache_L2_rdata,
   output logic         dcache_L2_resp,

   output logic [15:0]  L2_address,
   output logic         L2_read,
   output logic         L2_write,
   output logic [127:0] L2_wdata,
   input  logic [127:0] L2_rdata,
   input  logic         L2_resp,

   output logic         err_timeout
);

   localparam int unsigned TimerWidth = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TimerWidth-1:0] TimerLimit = TimerWidth'(TIMEOUT);
   localparam logic [TimerWidth-1:0] TimerMax   = '1;

   lc3b_arb_state         state_q, state_d;
   lc3b_arb_owner         last_grant_q, last_grant_d;
   logic [TimerWidth-1:0] timer_q, timer_d;
   logic                  err_q;

   logic        ireq, dreq, own_d, grant_active;
   lc3b_word    addr_sel;
   lc3b_L1_line wdata_sel;

   assign ireq         = icache_L2_read;
   assign dreq         = dcache_L2_read | dcache_L2_write;
   assign own_d        = (state_q == GRANT_D);
   assign grant_active = (state_q == GRANT_I) || (state_q == GRANT_D);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= ICACHE;
         timer_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         timer_q      <= timer_d;
         if ((TIMEOUT != 0) && grant_active && (timer_q == TimerLimit)) begin
            err_q <= 1'b1;
         end
      end
   end

   // Next-state logic; the timer is held at zero in IDLE so every grant starts counting fresh
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      timer_d      = timer_q;
      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            if (ireq && dreq) begin
               state_d = (last_grant_q == ICACHE) ? GRANT_D : GRANT_I;
            end else if (ireq) begin
               state_d = GRANT_I;
            end else if (dreq) begin
               state_d = GRANT_D;
            end
         end
         GRANT_I: begin
            if (L2_resp) begin
               last_grant_d = ICACHE;
               state_d      = RELEASE;
            end else if (timer_q != TimerMax) begin
               timer_d = timer_q + 1'b1;
            end
         end
         GRANT_D: begin
            if (L2_resp) begin
               last_grant_d = DCACHE;
               state_d      = RELEASE;
            end else if (timer_q != TimerMax) begin
               timer_d = timer_q + 1'b1;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   mux2 #(.Width(16)) u_addr_mux (
      .sel (own_d),
      .a   (icache_L2_address),
      .b   (dcache_L2_address),
      .f   (addr_sel)
   );

   mux2 #(.Width(128)) u_wdata_mux (
      .sel (own_d),
      .a   ('0),
      .b   (dcache_L2_wdata),
      .f   (wdata_sel)
   );

   // Output logic: strobes follow the owner's live request lines
   always_comb begin
      L2_address     = '0;
      L2_read        = 1'b0;
      L2_write       = 1'b0;
      L2_wdata       = '0;
      icache_L2_resp = 1'b0;
      dcache_L2_resp = 1'b0;
      unique case (state_q)
         GRANT_I: begin
            L2_address     = addr_sel;
            L2_read        = icache_L2_read;
            icache_L2_resp = L2_resp;
         end
         GRANT_D: begin
            L2_address     = addr_sel;
            L2_wdata       = wdata_sel;
            // A simultaneous read and write from the dcache is treated as a writeback
            L2_write       = dcache_L2_write;
            L2_read        = dcache_L2_read & ~dcache_L2_write;
            dcache_L2_resp = L2_resp;
         end
         default: ;
      endcase
   end

   assign icache_L2_rdata = L2_rdata;
   assign dcache_L2_rdata = L2_rdata;
   assign err_timeout     = err_q;

`ifndef SYNTHESIS
   a_no_rw_conflict : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == GRANT_D) |-> !(dcache_L2_read && dcache_L2_write));
   a_icache_holds : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == GRANT_I) |-> icache_L2_read);
   a_dcache_holds : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == GRANT_D) |-> (dcache_L2_read || dcache_L2_write));
`endif

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed self-checking bench for l1_l2_arbiter: isolated transfers, round-robin, timeout, reset.
module tb_l1_l2_arbiter;

   logic         clk;
   logic         rst_n;
   logic [15:0]  icache_L2_address;
   logic         icache_L2_read;
   logic [127:0] icache_L2_rdata;
   logic         icache_L2_resp;
   logic [15:0]  dcache_L2_address;
   logic         dcache_L2_read;
   logic         dcache_L2_write;
   logic [127:0] dcache_L2_wdata;
   logic [127:0] dcache_L2_rdata;
   logic         dcache_L2_resp;
   logic [15:0]  L2_address;
   logic         L2_read;
   logic         L2_write;
   logic [127:0] L2_wdata;
   logic [127:0] L2_rdata;
   logic         L2_resp;
   logic         err_timeout;

   int tests = 0;
   int fails = 0;

   localparam logic [127:0] LineA = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
   localparam logic [127:0] Victim = 128'hdead_beef_dead_beef_dead_beef_dead_beef;

   l1_l2_arbiter #(.TIMEOUT(8)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .icache_L2_address (icache_L2_address),
      .icache_L2_read    (icache_L2_read),
      .icache_L2_rdata   (icache_L2_rdata),
      .icache_L2_resp    (icache_L2_resp),
      .dcache_L2_address (dcache_L2_address),
      .dcache_L2_read    (dcache_L2_read),
      .dcache_L2_write   (dcache_L2_write),
      .dcache_L2_wdata   (dcache_L2_wdata),
      .dcache_L2_rdata   (dcache_L2_rdata),
      .dcache_L2_resp    (dcache_L2_resp),
      .L2_address        (L2_address),
      .L2_read           (L2_read),
      .L2_write          (L2_write),
      .L2_wdata          (L2_wdata),
      .L2_rdata          (L2_rdata),
      .L2_resp           (L2_resp),
      .err_timeout       (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n             = 1'b0;
      icache_L2_address = '0;
      icache_L2_read    = 1'b0;
      dcache_L2_address = '0;
      dcache_L2_read    = 1'b0;
      dcache_L2_write   = 1'b0;
      dcache_L2_wdata   = '0;
      L2_rdata          = '0;
      L2_resp           = 1'b0;
      #2;
      chk("rst_L2_read", L2_read, 0);
      chk("rst_L2_write", L2_write, 0);
      chk("rst_L2_address", L2_address, 0);
      chk("rst_err", err_timeout, 0);
      step();
      rst_n = 1'b1;
      step();

      // Isolated icache read, L2 answers in the 4th grant cycle
      icache_L2_read    = 1'b1;
      icache_L2_address = 16'h1230;
      #1;
      chk("t1_idle_no_strobe", L2_read, 0);
      step();
      chk("t1_L2_read", L2_read, 1);
      chk("t1_L2_address", L2_address, 16'h1230);
      chk("t1_L2_write", L2_write, 0);
      chk("t1_L2_wdata", L2_wdata, 0);
      step(); step(); step();
      chk("t1_no_early_resp", icache_L2_resp, 0);
      L2_resp  = 1'b1;
      L2_rdata = LineA;
      #1;
      chk("t1_icache_resp", icache_L2_resp, 1);
      chk("t1_icache_rdata", icache_L2_rdata, LineA);
      chk("t1_dcache_resp", dcache_L2_resp, 0);
      chk("t1_dcache_rdata", dcache_L2_rdata, LineA);
      step();
      L2_resp        = 1'b0;
      icache_L2_read = 1'b0;
      #1;
      chk("t1_release_resp", icache_L2_resp, 0);
      chk("t1_release_read", L2_read, 0);
      step();

      // dcache writeback
      dcache_L2_write   = 1'b1;
      dcache_L2_address = 16'h4010;
      dcache_L2_wdata   = Victim;
      step();
      chk("t2_L2_write", L2_write, 1);
      chk("t2_L2_read", L2_read, 0);
      chk("t2_L2_wdata", L2_wdata, Victim);
      chk("t2_L2_address", L2_address, 16'h4010);
      step();
      L2_resp = 1'b1;
      #1;
      chk("t2_dcache_resp", dcache_L2_resp, 1);
      chk("t2_icache_resp", icache_L2_resp, 0);
      step();
      L2_resp         = 1'b0;
      dcache_L2_write = 1'b0;
      #1;
      chk("t2_resp_once", dcache_L2_resp, 0);
      chk("t2_release_write", L2_write, 0);
      step();

      // Fresh reset, then both requesters held for 6 transactions: D,I,D,I,D,I
      rst_n = 1'b0;
      step();
      rst_n             = 1'b1;
      icache_L2_read    = 1'b1;
      icache_L2_address = 16'h1111;
      dcache_L2_read    = 1'b1;
      dcache_L2_address = 16'h2222;
      dcache_L2_wdata   = '0;
      for (int k = 0; k < 6; k++) begin
         logic exp_d;
         exp_d = ((k % 2) == 0);
         step();
         chk($sformatf("rr%0d_address", k), L2_address, exp_d ? 16'h2222 : 16'h1111);
         chk($sformatf("rr%0d_read", k), L2_read, 1);
         step();
         L2_resp  = 1'b1;
         L2_rdata = 128'(k);
         #1;
         chk($sformatf("rr%0d_dresp", k), dcache_L2_resp, exp_d);
         chk($sformatf("rr%0d_iresp", k), icache_L2_resp, !exp_d);
         step();
         L2_resp = 1'b0;
         #1;
         chk($sformatf("rr%0d_release", k), L2_read, 0);
         step();
      end
      icache_L2_read = 1'b0;
      dcache_L2_read = 1'b0;
      step();

      // L2 never answers: err_timeout rises and sticks, FSM stays granted
      dcache_L2_read    = 1'b1;
      dcache_L2_address = 16'h3000;
      step();
      chk("to_granted", L2_read, 1);
      repeat (5) step();
      chk("to_err_low_early", err_timeout, 0);
      repeat (7) step();
      chk("to_err_high", err_timeout, 1);
      chk("to_still_granted", L2_read, 1);
      repeat (8) step();
      chk("to_err_sticky", err_timeout, 1);
      chk("to_address_held", L2_address, 16'h3000);

      // Asynchronous reset mid-GRANT_D
      #3;
      L2_resp = 1'b1;
      rst_n   = 1'b0;
      #1;
      chk("ar_L2_read", L2_read, 0);
      chk("ar_L2_address", L2_address, 0);
      chk("ar_dcache_resp", dcache_L2_resp, 0);
      chk("ar_err", err_timeout, 0);
      L2_resp        = 1'b0;
      dcache_L2_read = 1'b0;
      #2;
      rst_n = 1'b1;
      step();
      icache_L2_read    = 1'b1;
      icache_L2_address = 16'h5550;
      step();
      chk("ar_fresh_read", L2_read, 1);
      chk("ar_fresh_address", L2_address, 16'h5550);
      step();
      L2_resp = 1'b1;
      #1;
      chk("ar_fresh_iresp", icache_L2_resp, 1);
      chk("ar_fresh_dresp", dcache_L2_resp, 0);
      step();
      L2_resp        = 1'b0;
      icache_L2_read = 1'b0;
      step();
      chk("ar_err_clear", err_timeout, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
